telemetry_framer: RTL and testbench

// - Downstream consumer of the sensor byte register map. On each start pulse it sweeps the map addresses FIRST_ADDR..LAST_ADDR.
// - Wraps the bytes read into a framed byte stream: sync, sequence, length, payload, check byte.
// - Feeds a valid/ready byte sink (UART TX / radio link). Asserts snap_hold so upstream capture holds sensor values stable while the payload is read.

---
 rtl/tlm_pkg.sv | 20 ++
 rtl/tlm_chk_acc.sv | 34 +++
 rtl/telemetry_framer.sv | 165 ++++++++++++++++
 tb/tb_telemetry_framer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlm_pkg.sv
// Shared types and constants for the telemetry framer: frame states, default sync bytes, CRC-8 step.
package tlm_pkg;

  typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, SEQ, LEN, PAYLOAD, CHK} state_t;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;
  localparam logic [7:0] CRC8_POLY     = 8'h07;

  // One byte through CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/tlm_chk_acc.sv
// Frame check accumulator. TLM_CRC8_EN selects CRC-8 (poly 0x07); otherwise the
// two's-complement of the byte sum, so covered bytes plus check sum to zero.
module tlm_chk_acc
  import tlm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  output logic [7:0] o_check
);

  logic [7:0] r_acc;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= 8'h00;
    end else if (i_en) begin
`ifdef TLM_CRC8_EN
      r_acc <= crc8_byte(r_acc, i_byte);
`else
      r_acc <= r_acc + i_byte;
`endif
    end
  end

`ifdef TLM_CRC8_EN
  assign o_check = r_acc;
`else
  assign o_check = 8'h00 - r_acc;
`endif

endmodule

// File: rtl/telemetry_framer.sv
// Sweeps the register map into a framed byte stream: sync, seq, len, payload, check.
// Check byte type is chosen by TLM_CRC8_EN (see tlm_chk_acc).
module telemetry_framer #(
  parameter logic [7:0] FIRST_ADDR = 8'd1,
  parameter logic [7:0] LAST_ADDR  = 8'd23,
  parameter logic [7:0] SYNC0      = tlm_pkg::SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1      = tlm_pkg::SYNC1_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       snap_hold,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam logic [7:0] LEN_BYTE = LAST_ADDR - FIRST_ADDR + 8'd1;

  // State names the byte currently held in the output register.
  tlm_pkg::state_t r_state, w_state_next;
  logic [7:0] r_out_data, w_out_data_next;
  logic       r_out_valid, w_out_valid_next;
  logic [7:0] r_idx, w_idx_next;
  logic       r_addr_en, w_addr_en_next;
  logic       r_snap_hold, w_snap_hold_next;
  logic [7:0] r_seq, w_seq_next;
  logic [7:0] r_drop_cnt, w_drop_cnt_next;

  logic       w_load;
  logic       w_chk_accept;
  logic       w_begin;
  logic       w_acc_clr;
  logic       w_acc_en;
  logic [7:0] w_acc_byte;
  logic [7:0] w_check;

  tlm_chk_acc u_chk_acc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_acc_clr),
    .i_en   (w_acc_en),
    .i_byte (w_acc_byte),
    .o_check(w_check)
  );

  assign w_load       = !r_out_valid || out_ready;
  assign w_chk_accept = (r_state == tlm_pkg::CHK) && r_out_valid && out_ready;
  assign w_begin      = start && ((r_state == tlm_pkg::IDLE) || w_chk_accept);

  always_comb begin
    w_state_next     = r_state;
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid;
    w_idx_next       = r_idx;
    w_addr_en_next   = r_addr_en;
    w_snap_hold_next = r_snap_hold;
    w_seq_next       = r_seq;
    w_drop_cnt_next  = r_drop_cnt;
    w_acc_clr        = 1'b0;
    w_acc_en         = 1'b0;
    w_acc_byte       = 8'h00;

    if (w_chk_accept) begin
      w_seq_next = r_seq + 8'd1;
    end

    if (start && (r_state != tlm_pkg::IDLE) && !w_chk_accept && (r_drop_cnt != 8'hFF)) begin
      w_drop_cnt_next = r_drop_cnt + 8'd1;
    end

    if (w_load) begin
      unique case (r_state)
        tlm_pkg::IDLE, tlm_pkg::CHK: begin
          if (w_begin) begin
            w_state_next     = tlm_pkg::SYNC0;
            w_out_data_next  = SYNC0;
            w_out_valid_next = 1'b1;
            w_snap_hold_next = 1'b1;
            w_acc_clr        = 1'b1;
          end else begin
            w_state_next     = tlm_pkg::IDLE;
            w_out_data_next  = 8'h00;
            w_out_valid_next = 1'b0;
          end
        end
        tlm_pkg::SYNC0: begin
          w_state_next    = tlm_pkg::SYNC1;
          w_out_data_next = SYNC1;
        end
        tlm_pkg::SYNC1: begin
          w_state_next    = tlm_pkg::SEQ;
          w_out_data_next = r_seq;
          w_acc_en        = 1'b1;
          w_acc_byte      = r_seq;
        end
        tlm_pkg::SEQ: begin
          w_state_next    = tlm_pkg::LEN;
          w_out_data_next = LEN_BYTE;
          w_acc_en        = 1'b1;
          w_acc_byte      = LEN_BYTE;
          w_idx_next      = FIRST_ADDR;
          w_addr_en_next  = 1'b1;
        end
        tlm_pkg::LEN, tlm_pkg::PAYLOAD: begin
          if (r_addr_en) begin
            w_state_next    = tlm_pkg::PAYLOAD;
            w_out_data_next = reg_data;
            w_acc_en        = 1'b1;
            w_acc_byte      = reg_data;
            if (r_idx == LAST_ADDR) begin
              // Last payload byte captured: upstream may refresh its snapshot.
              w_idx_next       = 8'h00;
              w_addr_en_next   = 1'b0;
              w_snap_hold_next = 1'b0;
            end else begin
              w_idx_next = r_idx + 8'd1;
            end
          end else begin
            w_state_next    = tlm_pkg::CHK;
            w_out_data_next = w_check;
          end
        end
        default: begin
          w_state_next     = tlm_pkg::IDLE;
          w_out_valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= tlm_pkg::IDLE;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_idx       <= 8'h00;
      r_addr_en   <= 1'b0;
      r_snap_hold <= 1'b0;
      r_seq       <= 8'h00;
      r_drop_cnt  <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
      r_idx       <= w_idx_next;
      r_addr_en   <= w_addr_en_next;
      r_snap_hold <= w_snap_hold_next;
      r_seq       <= w_seq_next;
      r_drop_cnt  <= w_drop_cnt_next;
    end
  end

  assign reg_addr  = r_addr_en ? r_idx : 8'h00;
  assign snap_hold = r_snap_hold;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != tlm_pkg::IDLE);
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_telemetry_framer.sv
// Scoreboard bench for telemetry_framer: expected frames are queued at each accepted start
// and compared byte by byte on every valid/ready handshake.
module tb_telemetry_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       snap_hold;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic [7:0] drop_cnt;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_seq = 8'h00;
  bit         map_mode = 1'b0;
  bit         rand_ready = 1'b0;
  bit         ready_level = 1'b1;

  localparam logic [7:0] M_FIRST = 8'd1;
  localparam logic [7:0] M_LAST  = 8'd23;

  telemetry_framer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .snap_hold(snap_hold),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Register map model: either all zero or each address returns itself.
  assign reg_data = map_mode ? reg_addr : 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC-8 reference (poly 0x07, MSB first).
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ b[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic push_frame();
    logic [7:0] sum;
    logic [7:0] crc;
    logic [7:0] len;
    logic [7:0] b;
    len = M_LAST - M_FIRST + 8'd1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(m_seq);
    exp_q.push_back(len);
    sum = m_seq + len;
    crc = ref_crc(ref_crc(8'h00, m_seq), len);
    for (int a = M_FIRST; a <= M_LAST; a++) begin
      b = map_mode ? 8'(a) : 8'h00;
      exp_q.push_back(b);
      sum = sum + b;
      crc = ref_crc(crc, b);
    end
`ifdef TLM_CRC8_EN
    exp_q.push_back(crc);
`else
    exp_q.push_back(8'h00 - sum);
`endif
    m_seq = m_seq + 8'd1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    push_frame();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int i;
    i = 0;
    while ((busy || exp_q.size() != 0) && i < max_cycles) begin
      @(posedge clk);
      #1;
      i++;
    end
    check_val(tag, (i < max_cycles), 1);
  endtask

  // Sink ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // Monitor: handshake decided by values stable at the falling edge.
  initial begin
    logic       stall_prev;
    logic [7:0] held_data;
    logic [7:0] held_addr;
    logic [7:0] got;
    stall_prev = 1'b0;
    held_data  = 8'h00;
    held_addr  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_val("stall_data", out_data, held_data);
          check_val("stall_addr", reg_addr, held_addr);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_byte", out_data, 32'hFFFF_FFFF);
          end else begin
            got = exp_q.pop_front();
            check_val("stream_byte", out_data, got);
            $display("byte %02h expected %02h q=%0d", out_data, got, exp_q.size());
          end
        end
        stall_prev = out_valid && !out_ready;
        held_data  = out_data;
        held_addr  = reg_addr;
      end
    end
  end

  initial begin
    int busy_cycles;
    int snap_cycles;
    int valid_cycles;
    int guard;

    rst = 1'b1;
    tick(3);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_snap_hold", snap_hold, 0);
    check_val("rst_drop_cnt", drop_cnt, 0);
    check_val("rst_reg_addr", reg_addr, 0);
    check_val("rst_out_data", out_data, 0);
    rst = 1'b0;
    tick(2);

    // Zero map, always-ready sink: 28 back-to-back bytes.
    map_mode = 1'b0;
    pulse_start();
    check_val("lat_valid", out_valid, 1);
    check_val("lat_sync0", out_data, 8'hA5);
    check_val("lat_busy", busy, 1);
    check_val("lat_snap", snap_hold, 1);
    busy_cycles  = 1;
    snap_cycles  = 1;
    valid_cycles = 1;
    guard        = 0;
    while (busy && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
      if (busy) busy_cycles++;
      if (snap_hold) snap_cycles++;
      if (out_valid) valid_cycles++;
    end
    check_val("f1_busy_cycles", busy_cycles, 28);
    check_val("f1_valid_cycles", valid_cycles, 28);
    check_val("f1_snap_cycles", snap_cycles, 26);
    check_val("f1_drained", exp_q.size(), 0);

    // Address-echo map.
    map_mode = 1'b1;
    pulse_start();
    wait_idle("f2_done", 200);

    // Random sink backpressure, two frames.
    rand_ready = 1'b1;
    tick(1);
    pulse_start();
    wait_idle("f3_done", 1000);
    pulse_start();
    wait_idle("f4_done", 1000);
    rand_ready  = 1'b0;
    ready_level = 1'b1;
    tick(2);

    // CHK accepted together with a new start: SYNC0 follows immediately.
    map_mode = 1'b0;
    pulse_start();
    tick(27);
    start = 1'b1;
    push_frame();
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("b2b_valid", out_valid, 1);
    check_val("b2b_sync0", out_data, 8'hA5);
    check_val("b2b_no_drop", drop_cnt, 0);
    wait_idle("b2b_done", 200);

    // Three starts mid-frame are dropped.
    map_mode = 1'b1;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      tick(5);
      start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    wait_idle("drop3_done", 200);
    check_val("drop_cnt_3", drop_cnt, 3);
    pulse_start();
    wait_idle("after_drop_done", 200);

    // Saturation: 300 starts while stalled on SYNC0.
    ready_level = 1'b0;
    tick(2);
    pulse_start();
    start = 1'b1;
    tick(300);
    start = 1'b0;
    check_val("drop_cnt_sat", drop_cnt, 8'hFF);
    check_val("sat_hold_valid", out_valid, 1);
    check_val("sat_hold_data", out_data, 8'hA5);
    ready_level = 1'b1;
    wait_idle("sat_done", 400);

    // Reset in the middle of the payload.
    map_mode = 1'b1;
    pulse_start();
    guard = 0;
    while (reg_addr != 8'd9 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val("mid_reach_addr9", reg_addr, 9);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_snap", snap_hold, 0);
    check_val("mid_rst_drop", drop_cnt, 0);
    check_val("mid_rst_addr", reg_addr, 0);
    rst   = 1'b0;
    m_seq = 8'h00;
    tick(2);
    pulse_start();
    check_val("post_rst_sync0", out_data, 8'hA5);
    wait_idle("post_rst_done", 200);

    tick(3);
    check_val("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
